// File: rtl/context_seq_pkg.sv
// Shared state type and default sizing for the context sequencer.
package context_seq_pkg;

   localparam int DEF_CTX_W    = 16;
   localparam int DEF_MAX_PEND = 2;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      RUN   = 3'd2,
      DRAIN = 3'd3,
      FLUSH = 3'd4,
      DONE  = 3'd5
   } ctx_state_t;

endpackage

// File: rtl/ctx_pend_counter.sv
// Saturating up/down counter of contexts that have finished computing but
// have not yet been switched out. A simultaneous inc and dec cancel, and the
// error outputs flag attempts to step past either end.
module ctx_pend_counter #(
   parameter int MAX_PEND = 2,
   parameter int PEND_W   = $clog2(MAX_PEND + 1)
) (
   input  logic              i_clk,
   input  logic              i_rstn,
   input  logic              clr,
   input  logic              en,
   input  logic              inc,
   input  logic              dec,
   output logic [PEND_W-1:0] cnt,
   output logic [PEND_W-1:0] cnt_next,
   output logic              ovf_err,
   output logic              unf_err
);

   localparam logic [PEND_W-1:0] CNT_MAX = PEND_W'(MAX_PEND);
   localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

   logic step_up;
   logic step_dn;

   assign step_up = en & inc & ~dec;
   assign step_dn = en & dec & ~inc;
   assign ovf_err = step_up & (cnt == CNT_MAX);
   assign unf_err = step_dn & (cnt == '0);

   // Next count: clear wins, otherwise step once, holding at either limit.
   always_comb begin
      cnt_next = cnt;
      if (clr) begin
         cnt_next = '0;
      end else if (step_up && !ovf_err) begin
         cnt_next = cnt + CNT_ONE;
      end else if (step_dn && !unf_err) begin
         cnt_next = cnt - CNT_ONE;
      end
   end

   // Count register.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_next;
      end
   end

endmodule

// File: rtl/context_sequencer.sv
// Context-level job sequencer driving the context switch controller: clears
// the datapath, runs N contexts, throttles on outstanding switches, drains,
// and handles abort by forcing one last switch.
module context_sequencer
   import context_seq_pkg::*;
#(
   parameter int  CTX_W    = DEF_CTX_W,
   parameter int  MAX_PEND = DEF_MAX_PEND,
   localparam int PEND_W   = $clog2(MAX_PEND + 1)
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_start,
   input  logic [CTX_W-1:0] i_nctx,
   input  logic             i_abort,
   input  logic             i_feed_valid,
   input  logic             i_out_ready,
   input  logic             i_cdone,
   input  logic             i_cswitch_done,
   output logic             o_clear,
   output logic             o_pipeline_en,
   output logic             o_cswitch_en,
   output logic             o_cswitch_force,
   output logic [CTX_W-1:0] o_ctx_idx,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_aborted,
   output logic             o_err
);

   localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);
   localparam logic [CTX_W-1:0]  CTX_ONE  = CTX_W'(1);

   ctx_state_t        state_q;
   ctx_state_t        state_d;
   logic [CTX_W-1:0]  nctx_q;
   logic [CTX_W-1:0]  cdone_cnt;
   logic [CTX_W-1:0]  sw_cnt;
   logic [CTX_W-1:0]  sw_next;
   logic [CTX_W-1:0]  nctx_m1;
   logic [PEND_W-1:0] pend;
   logic [PEND_W-1:0] pend_next;
   logic              aborted_q;
   logic              flush_seen_q;
   logic              err_q;
   logic              start_acc;
   logic              cnt_active;
   logic              in_flush;
   logic              ovf_err;
   logic              unf_err;
   logic              err_set;

   assign start_acc  = (state_q == IDLE) & i_start;
   assign in_flush   = (state_q == FLUSH);
   assign cnt_active = (state_q == RUN) | (state_q == DRAIN) | in_flush;
   assign sw_next    = (cnt_active & i_cswitch_done) ? sw_cnt + CTX_ONE : sw_cnt;
   assign nctx_m1    = nctx_q - CTX_ONE;
   // Underflow during FLUSH is expected: the forced switch may have no pending context.
   assign err_set    = ovf_err | (unf_err & ~in_flush) | ((state_q == DRAIN) & i_cdone);

   ctx_pend_counter #(
      .MAX_PEND (MAX_PEND),
      .PEND_W   (PEND_W)
   ) u_pend (
      .i_clk    (i_clk),
      .i_rstn   (i_rstn),
      .clr      (start_acc),
      .en       (cnt_active),
      .inc      (i_cdone),
      .dec      (i_cswitch_done),
      .cnt      (pend),
      .cnt_next (pend_next),
      .ovf_err  (ovf_err),
      .unf_err  (unf_err)
   );

   // Next-state logic; abort outranks every normal transition it can interrupt.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (i_start) state_d = CLEAR;
         CLEAR: begin
            if (i_abort)              state_d = FLUSH;
            else if (nctx_q == '0)    state_d = DONE;
            else                      state_d = RUN;
         end
         RUN: begin
            if (i_abort)                              state_d = FLUSH;
            else if (i_cdone && cdone_cnt == nctx_m1) state_d = DRAIN;
         end
         // Exit on the edge that retires the last switch so o_done follows it directly.
         DRAIN: begin
            if (i_abort)                                    state_d = FLUSH;
            else if (pend_next == '0 && sw_next == nctx_q)  state_d = DONE;
         end
         FLUSH: if (i_cswitch_done) state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM state plus the flags that shape FLUSH and DONE outputs.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q      <= IDLE;
         flush_seen_q <= 1'b0;
         aborted_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         flush_seen_q <= in_flush;
         if (state_d == DONE) aborted_q <= in_flush;
      end
   end

   // Job counters and sticky error; o_ctx_idx keeps its value until the next start.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         nctx_q    <= '0;
         cdone_cnt <= '0;
         sw_cnt    <= '0;
         err_q     <= 1'b0;
      end else if (start_acc) begin
         nctx_q    <= i_nctx;
         cdone_cnt <= '0;
         sw_cnt    <= '0;
         err_q     <= 1'b0;
      end else begin
         if (cnt_active && i_cdone) cdone_cnt <= cdone_cnt + CTX_ONE;
         sw_cnt <= sw_next;
         if (err_set) err_q <= 1'b1;
      end
   end

   // Control outputs; pipeline and switch enables follow live inputs in RUN/DRAIN.
   always_comb begin
      o_clear         = 1'b0;
      o_pipeline_en   = 1'b0;
      o_cswitch_en    = 1'b0;
      o_cswitch_force = 1'b0;
      case (state_q)
         CLEAR: o_clear = 1'b1;
         RUN: begin
            o_pipeline_en = i_feed_valid & (pend < PEND_MAX);
            o_cswitch_en  = i_out_ready;
         end
         DRAIN: begin
            o_pipeline_en = 1'b1;
            o_cswitch_en  = i_out_ready;
         end
         FLUSH: begin
            o_pipeline_en   = 1'b1;
            o_cswitch_en    = 1'b1;
            o_cswitch_force = ~flush_seen_q;
         end
         default: ;
      endcase
   end

   assign o_ctx_idx = sw_cnt;
   assign o_busy    = (state_q != IDLE);
   assign o_done    = (state_q == DONE);
   assign o_aborted = (state_q == DONE) & aborted_q;
   assign o_err     = err_q;

endmodule

// File: doc/context_sequencer.md
Name: context_sequencer

Overview:
- Context-level control FSM that sits directly above the context switch controller in the sauria_core control path.
- Consumes the controller's per-context cdone pulses and cswitch_done pulses. Drives the controller's clear, pipeline enable, context-switch enable and force inputs.
- Sequences a job of N contexts. Limits how many finished-but-unswitched contexts may be outstanding. Applies backpressure from the partial-sum output buffer and supports an abort that forces a final context switch.

Parameters:
- CTX_W, 16, width of the context count and context index.
- MAX_PEND, 2, maximum contexts with cdone received but cswitch_done not yet received (1..3).
- PEND_W, $clog2(MAX_PEND+1), pending counter width (derived; not overridden).

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  reset, asynchronous, active-low
- i_start  in  1  start job pulse; sampled in IDLE only
- i_nctx  in  CTX_W  number of contexts in the job; captured on i_start
- i_abort  in  1  abort request pulse
- i_feed_valid  in  1  weight and activation feeders both able to pop this cycle
- i_out_ready  in  1  psum output buffer can accept one context drain
- i_cdone  in  1  context done pulse from the switch controller
- i_cswitch_done  in  1  context switch complete pulse from the switch controller
- o_clear  out  1  clear to the switch controller, counters and feeders
- o_pipeline_en  out  1  pipeline enable
- o_cswitch_en  out  1  context switch enable
- o_cswitch_force  out  1  force context switch
- o_ctx_idx  out  CTX_W  number of contexts fully switched out in the current job
- o_busy  out  1  job in progress (state != IDLE)
- o_done  out  1  one-cycle job complete pulse
- o_aborted  out  1  qualifies o_done: job ended by abort
- o_err  out  1  sticky protocol error

Behaviour:
- Reset: state=IDLE; all counters 0; every output 0, including o_err.
- State encoding: IDLE, CLEAR, RUN, DRAIN, FLUSH, DONE.
- Registers: nctx_q, cdone_cnt (CTX_W), sw_cnt (CTX_W), pend (PEND_W). o_ctx_idx = sw_cnt.
- IDLE:
  - On i_start: capture i_nctx, clear cdone_cnt, sw_cnt and pend, go to CLEAR.
  - i_abort, i_cdone and i_cswitch_done are ignored.
- CLEAR:
  - o_clear=1 for exactly one cycle; all other control outputs 0.
  - Next state is DONE if nctx_q==0 (o_aborted=0), else RUN.
- RUN:
  - o_pipeline_en = i_feed_valid && (pend < MAX_PEND). This output is Mealy.
  - o_cswitch_en = i_out_ready. o_cswitch_force = 0.
- Counter updates, in RUN, DRAIN and FLUSH:
  - i_cdone increments pend and cdone_cnt.
  - i_cswitch_done decrements pend and increments sw_cnt.
  - If both arrive in the same cycle, pend is unchanged and both counts increment.
- RUN to DRAIN: when i_cdone arrives with cdone_cnt==nctx_q-1.
- DRAIN:
  - o_pipeline_en=1 so the switch counter keeps advancing; o_cswitch_en = i_out_ready.
  - Go to DONE in the cycle after pend reaches 0 and sw_cnt equals nctx_q.
- Abort: i_abort in CLEAR, RUN or DRAIN moves to FLUSH next cycle. Ignored in FLUSH and DONE.
- FLUSH:
  - First cycle: o_cswitch_force=1, o_pipeline_en=1, o_cswitch_en=1.
  - After that: force=0, pipeline_en=1, cswitch_en=1.
  - i_cdone in FLUSH is counted but does not change state.
  - The first i_cswitch_done after entering FLUSH moves to DONE with o_aborted=1.
- DONE: o_done=1 for one cycle, o_aborted valid in that cycle, then IDLE. o_ctx_idx holds its value until the next i_start.
- Protocol errors (set o_err sticky; cleared only by reset or i_start):
  - i_cswitch_done while pend==0 (outside FLUSH). pend saturates at 0.
  - i_cdone while pend==MAX_PEND. pend saturates.
  - i_cdone in DRAIN.
- Arithmetic: counters compare against nctx_q only; no modular wrap. nctx_q up to 2^CTX_W-1.
- i_start outside IDLE is ignored.
- Asynchronous reset mid-job: returns to IDLE immediately, all outputs 0, no o_done.

Decomposition:
- Package context_seq_pkg holds:
  - typedef enum ctx_state_t {IDLE, CLEAR, RUN, DRAIN, FLUSH, DONE};
  - default localparams CTX_W=16 and MAX_PEND=2.
- One sub-module: ctx_pend_counter, an up/down saturating counter with error outputs for overflow and underflow.
- The FSM and job counters stay in context_sequencer.

Test Plan:
- Normal job: nctx=3, feed_valid=1, out_ready=1, cdone at cycles 10/20/30, cswitch_done 12 cycles after each cdone -> o_clear pulse in cycle 1; o_ctx_idx goes 1,2,3; o_done with o_aborted=0 one cycle after third cswitch_done; o_err=0.
- nctx=0: start -> one o_clear cycle, then o_done the next cycle; o_pipeline_en never asserted.
- Pending limit with MAX_PEND=2: two cdones with no cswitch_done -> o_pipeline_en=0 while feed_valid=1; a cswitch_done re-enables it in the next cycle. A third cdone sets o_err.
- Backpressure: out_ready=0 for 8 cycles during DRAIN -> o_cswitch_en=0 in those cycles; job completes after out_ready returns; sw_cnt=nctx.
- Abort in RUN after 1 of 4 contexts -> exactly one cycle of o_cswitch_force; next cswitch_done -> o_done with o_aborted=1, o_ctx_idx=2.
- Simultaneous events: cdone and cswitch_done in the same cycle -> pend unchanged; then an asynchronous reset mid-RUN -> all outputs 0, state IDLE, no o_done.
